// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_pkg
// Description : Shared definitions for the serial 7-segment display stream:
//               segment pattern constants, reader state encoding and the
//               pattern-to-digit decode function.
// Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

  localparam int c_seg_bits = 7;
  localparam int c_acc_w    = 10;  // holds up to 999 plus the final weight of 1000

  // Segment patterns, bit6..bit0; bit0 is the first bit on the wire
  localparam logic [6:0] c_seg_0 = 7'b1111110;
  localparam logic [6:0] c_seg_1 = 7'b1000010;
  localparam logic [6:0] c_seg_2 = 7'b0110111;
  localparam logic [6:0] c_seg_3 = 7'b0100101;
  localparam logic [6:0] c_seg_4 = 7'b1001011;
  localparam logic [6:0] c_seg_5 = 7'b1101101;
  localparam logic [6:0] c_seg_6 = 7'b1111101;
  localparam logic [6:0] c_seg_7 = 7'b1000111;
  localparam logic [6:0] c_seg_8 = 7'b1111111;
  localparam logic [6:0] c_seg_9 = 7'b1101111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    STEP   = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Returns {valid, digit}; unknown patterns give valid=0 and digit=0
  function automatic logic [4:0] seg_to_digit(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      c_seg_0: r = {1'b1, 4'd0};
      c_seg_1: r = {1'b1, 4'd1};
      c_seg_2: r = {1'b1, 4'd2};
      c_seg_3: r = {1'b1, 4'd3};
      c_seg_4: r = {1'b1, 4'd4};
      c_seg_5: r = {1'b1, 4'd5};
      c_seg_6: r = {1'b1, 4'd6};
      c_seg_7: r = {1'b1, 4'd7};
      c_seg_8: r = {1'b1, 4'd8};
      c_seg_9: r = {1'b1, 4'd9};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_to_digit.sv
`default_nettype none
// ============================================================================
// Module      : seg7_to_digit
// Description : Combinational 7-segment pattern to BCD digit decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_to_digit
  import display_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       digit_valid
);

  assign {digit_valid, digit} = seg_to_digit(seg);

endmodule
`default_nettype wire

// File: rtl/display_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : display_stream_reader
// Description : Reads a multi-digit value back from the serial 7-segment
//               display stream, rebuilding the binary value and flagging
//               invalid patterns or loss of alignment with the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module display_stream_reader
  import display_pkg::*;
#(
  parameter int MAX_DIGITS = 3,
  parameter int VALUE_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         digit_count,
  input  logic               led_data,
  input  logic               peer_busy,
  output logic               next_led,
  output logic [VALUE_W-1:0] value,
  output logic               valid,
  output logic               error,
  output logic               busy
);

  localparam logic [1:0] c_max_n = 2'(MAX_DIGITS);

  state_t             r_state;
  state_t             w_state_next;
  logic [2:0]         r_bit_idx;
  logic [1:0]         r_digit_idx;
  logic [1:0]         r_num_digits;
  logic [6:0]         r_seg;
  logic [c_acc_w-1:0] r_acc;
  logic [c_acc_w-1:0] r_weight;
  logic               r_first;
  logic [VALUE_W-1:0] r_value;
  logic               r_valid;
  logic               r_error;
  logic               r_busy;

  logic [1:0]         w_num_digits;
  logic [1:0]         w_digit_inc;
  logic               w_accept;
  logic               w_desync;
  logic               w_last_bit;
  logic               w_last_digit;
  logic [3:0]         w_digit;
  logic               w_digit_ok;
  logic [c_acc_w-1:0] w_term;
  logic [c_acc_w-1:0] w_weight_x10;

  seg7_to_digit u_seg7_to_digit (
    .seg         (r_seg),
    .digit       (w_digit),
    .digit_valid (w_digit_ok)
  );

  assign w_accept     = start && !peer_busy;
  // The first bit is presented while the decoder is still idle; every later
  // bit must be seen with the decoder stepping.
  assign w_desync     = !r_first && !peer_busy;
  assign w_last_bit   = (r_bit_idx == 3'd6);
  assign w_digit_inc  = r_digit_idx + 2'd1;
  assign w_last_digit = (w_digit_inc == r_num_digits);
  assign w_term       = w_digit_ok ? (c_acc_w'(w_digit) * r_weight) : '0;
  assign w_weight_x10 = (r_weight << 3) + (r_weight << 1);

  // Effective digit count: zero reads one digit, clamp to the supported maximum
  always_comb begin
    w_num_digits = digit_count;
    if (digit_count == 2'd0) begin
      w_num_digits = 2'd1;
    end else if (digit_count > c_max_n) begin
      w_num_digits = c_max_n;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and the advance strobe (one cycle per STEP)
  always_comb begin
    w_state_next = r_state;
    next_led     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = SAMPLE;
        end
      end
      SAMPLE: begin
        w_state_next = w_desync ? DONE : STEP;
      end
      STEP: begin
        next_led = 1'b1;
        if (!w_last_bit) begin
          w_state_next = SAMPLE;
        end else if (w_last_digit) begin
          w_state_next = DONE;
        end else begin
          w_state_next = SAMPLE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Bit capture, digit accumulation and result/flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_idx    <= '0;
      r_digit_idx  <= '0;
      r_num_digits <= '0;
      r_seg        <= '0;
      r_acc        <= '0;
      r_weight     <= '0;
      r_first      <= 1'b0;
      r_value      <= '0;
      r_valid      <= 1'b0;
      r_error      <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_num_digits <= w_num_digits;
            r_acc        <= '0;
            r_weight     <= c_acc_w'(1);
            r_error      <= 1'b0;
            r_busy       <= 1'b1;
            r_bit_idx    <= '0;
            r_digit_idx  <= '0;
            r_first      <= 1'b1;
          end
        end
        SAMPLE: begin
          r_seg[r_bit_idx] <= led_data;
          r_first          <= 1'b0;
          if (w_desync) begin
            r_error <= 1'b1;
          end
        end
        STEP: begin
          if (!w_last_bit) begin
            r_bit_idx <= r_bit_idx + 3'd1;
          end else begin
            r_acc       <= r_acc + w_term;
            r_weight    <= w_weight_x10;
            r_bit_idx   <= '0;
            r_digit_idx <= w_digit_inc;
            if (!w_digit_ok) begin
              r_error <= 1'b1;
            end
          end
        end
        DONE: begin
          r_value <= {{(VALUE_W-c_acc_w){1'b0}}, r_acc};
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign value = r_value;
  assign valid = r_valid;
  assign error = r_error;
  assign busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_display_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_stream_reader
// Description : Self-checking bench for display_stream_reader with a
//               behavioural decoder peer and an expected-result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_stream_reader;

  typedef struct {
    int value;
    int error;
    int pulses;
    int latency;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  digit_count;
  logic        led_data;
  logic        peer_busy;
  logic        next_led;
  logic [15:0] value;
  logic        valid;
  logic        error;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int edge_cnt     = 0;
  int pulse_cnt    = 0;
  logic prev_nl    = 1'b0;
  exp_t sb[$];

  // Behavioural decoder peer
  logic [6:0] peer_pat [3];
  int         peer_n;
  int         peer_drop;
  int         peer_pos;
  int         peer_d;
  int         peer_b;
  logic       peer_busy_r;
  logic       peer_dropped;
  logic       peer_busy_force;

  display_stream_reader #(
    .MAX_DIGITS (3),
    .VALUE_W    (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .digit_count (digit_count),
    .led_data    (led_data),
    .peer_busy   (peer_busy),
    .next_led    (next_led),
    .value       (value),
    .valid       (valid),
    .error       (error),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b1000010;
      2: return 7'b0110111;
      3: return 7'b0100101;
      4: return 7'b1001011;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b1000111;
      8: return 7'b1111111;
      default: return 7'b1101111;
    endcase
  endfunction

  // Present the current bit of the current digit
  always_comb begin
    peer_d   = peer_pos / 7;
    peer_b   = peer_pos % 7;
    led_data = (peer_d < 3) ? peer_pat[peer_d][peer_b] : 1'b0;
  end

  assign peer_busy = peer_busy_force | peer_busy_r;

  // Peer stepping: advance on next_led, go idle after the last bit or when
  // told to drop out of the stream early
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peer_pos     <= 0;
      peer_busy_r  <= 1'b0;
      peer_dropped <= 1'b0;
    end else if (start && !peer_busy) begin
      peer_pos     <= 0;
      peer_busy_r  <= 1'b0;
      peer_dropped <= 1'b0;
    end else if (next_led && !peer_dropped) begin
      if (peer_pos + 1 == 7 * peer_n) begin
        peer_pos    <= 0;
        peer_busy_r <= 1'b0;
      end else begin
        peer_pos     <= peer_pos + 1;
        peer_busy_r  <= !(peer_drop != 0 && peer_pos + 1 == peer_drop);
        peer_dropped <= (peer_drop != 0 && peer_pos + 1 == peer_drop);
      end
    end
  end

  always @(posedge clk) edge_cnt++;

  // Pulse counter and back-to-back strobe check
  always @(negedge clk) begin
    if (next_led) begin
      pulse_cnt++;
      check("next_led_gap", {31'd0, prev_nl}, 32'd0);
    end
    prev_nl = next_led;
  end

  task automatic run_read(input string tag, input int dc, input int n,
                          input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                          input int drop, input int exp_val, input int exp_err,
                          input int mid_start);
    exp_t e;
    exp_t ex;
    int   start_edge;
    int   pulse_base;
    int   cycles;
    peer_pat[0] = p0;
    peer_pat[1] = p1;
    peer_pat[2] = p2;
    peer_n      = n;
    peer_drop   = drop;
    e.value     = exp_val;
    e.error     = exp_err;
    e.pulses    = (drop != 0) ? drop : 7 * n;
    e.latency   = (drop != 0) ? 2 * drop + 2 : 14 * n + 1;
    sb.push_back(e);
    digit_count = dc[1:0];
    start       = 1'b1;
    start_edge  = edge_cnt + 1;
    pulse_base  = pulse_cnt;
    @(negedge clk);
    start  = 1'b0;
    cycles = 0;
    while (!valid && cycles < 400) begin
      start = (mid_start != 0 && cycles == mid_start);
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    if (!valid) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      ex = sb.pop_front();
      check({tag, "_value"},   {16'd0, value}, ex.value);
      check({tag, "_error"},   {31'd0, error}, ex.error);
      check({tag, "_latency"}, edge_cnt - start_edge, ex.latency);
      @(negedge clk);
      check({tag, "_valid_pulse"}, {31'd0, valid}, 32'd0);
      check({tag, "_busy_after"},  {31'd0, busy},  32'd0);
      check({tag, "_pulses"}, pulse_cnt - pulse_base, ex.pulses);
      if (drop == 0) check({tag, "_peer_idle"}, {31'd0, peer_busy}, 32'd0);
    end
  endtask

  task automatic read_value(input string tag, input int dc, input int n,
                            input int data, input int mid_start);
    run_read(tag, dc, n, seg_of(data % 10), seg_of((data / 10) % 10),
             seg_of((data / 100) % 10), 0, data % (10 ** n), 0, mid_start);
  endtask

  initial begin
    int pulse_base;
    logic saw_busy;
    rst_n           = 1'b0;
    start           = 1'b0;
    digit_count     = 2'd0;
    peer_busy_force = 1'b0;
    peer_n          = 1;
    peer_drop       = 0;
    for (int i = 0; i < 3; i++) peer_pat[i] = 7'd0;
    repeat (3) @(negedge clk);
    check("rst_next_led", {31'd0, next_led}, 32'd0);
    check("rst_valid",    {31'd0, valid},    32'd0);
    check("rst_error",    {31'd0, error},    32'd0);
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_value",    {16'd0, value},    32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    read_value("d3_472",  3, 3, 472,  0);
    read_value("d0_5",    0, 1, 5,    0);
    read_value("d1_8",    1, 1, 8,    0);
    read_value("d2_1234", 2, 2, 1234, 0);
    read_value("busy_start", 3, 3, 305, 20);

    // Invalid middle digit: 2 + 0*10 + 7*100, error flagged, full stream read
    run_read("bad_pat", 3, 3, seg_of(2), 7'b0000000, seg_of(7), 0, 702, 1, 0);

    // Peer drops out after the third pulse: no digit completed
    run_read("desync", 3, 3, seg_of(2), seg_of(7), seg_of(4), 3, 0, 1, 0);

    // A clean read clears the error again
    read_value("recover_9", 1, 1, 9, 0);

    // Asynchronous reset in the middle of a read
    peer_n      = 3;
    peer_drop   = 0;
    peer_pat[0] = seg_of(2);
    peer_pat[1] = seg_of(7);
    peer_pat[2] = seg_of(4);
    digit_count = 2'd3;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_busy_before_rst", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_next_led", {31'd0, next_led}, 32'd0);
    check("mid_rst_valid",    {31'd0, valid},    32'd0);
    check("mid_rst_error",    {31'd0, error},    32'd0);
    check("mid_rst_busy",     {31'd0, busy},     32'd0);
    check("mid_rst_value",    {16'd0, value},    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Start while the decoder reports busy is ignored
    peer_busy_force = 1'b1;
    pulse_base      = pulse_cnt;
    saw_busy        = 1'b0;
    digit_count     = 2'd1;
    start           = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      saw_busy = saw_busy | busy | valid;
      @(negedge clk);
    end
    check("peer_busy_start_busy",   {31'd0, saw_busy}, 32'd0);
    check("peer_busy_start_pulses", pulse_cnt - pulse_base, 32'd0);
    peer_busy_force = 1'b0;
    @(negedge clk);

    read_value("final_90", 2, 2, 90, 0);
    check("sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/display_stream_reader.md
Name: display_stream_reader

Overview:
- Consumer end of the serial 7-segment display stream.
- Drives `next_led`, samples `led_data` from the display decoder, and reassembles each 7-bit segment pattern into a digit.
- Rebuilds the binary value and checks protocol alignment.
- Used for display loopback self-test and for reading the displayed value back into the control logic.

Parameters:
- MAX_DIGITS, 3, largest digit count accepted (must fit the 2-bit digit_count field).
- VALUE_W, 16, width of the reconstructed value output.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to read one value.
- digit_count  in  2  digits to read; 0 is treated as 1.
- led_data  in  1  serial segment bit from the decoder.
- peer_busy  in  1  decoder busy flag.
- next_led  out  1  advance strobe to the decoder.
- value  out  VALUE_W  reconstructed value, zero-extended.
- valid  out  1  one-cycle pulse, value and error are final.
- error  out  1  invalid pattern or desync seen in the last read; valid with valid.
- busy  out  1  read in progress.

Behaviour:
- Reset (async, rst_n low):
  - next_led, valid, error, busy, value all 0; state IDLE.
  - Reset wins over a simultaneous start.
  - Reset mid-read abandons the read immediately. The decoder must be reset in the same event.
- Stream protocol:
  - Per digit, 7 bits, segment index 0 first. Digits are sent least significant first.
  - The bit for the current index is valid on led_data while the decoder is idle or stepping.
  - Each next_led cycle advances the index by one.
  - The 7th pulse of the last digit returns the decoder to idle.
  - Total pulses per read: 7*N, where N = max(digit_count, 1).
- Patterns (bit6..bit0): 0=1111110, 1=1000010, 2=0110111, 3=0100101, 4=1001011, 5=1101101, 6=1111101, 7=1000111, 8=1111111, 9=1101111. Any other pattern is invalid.
- States:
  - IDLE:
    - start with peer_busy=0 → latch N, clear accumulator, weight=1, error=0, busy=1 → SAMPLE.
    - start with peer_busy=1 is ignored.
  - SAMPLE:
    - Store led_data at bit position bit_idx → STEP.
    - Alignment check: for every bit except the very first of the read, peer_busy must be 1. Otherwise set error, skip to DONE, and issue no further next_led.
  - STEP:
    - next_led=1 for exactly this cycle.
    - If bit_idx<6: bit_idx+1 → SAMPLE.
    - Else decode the 7-bit pattern.
      - Valid pattern: accumulator += digit*weight. Weight update is weight*10, computed as (w<<3)+(w<<1).
      - Invalid pattern: set error, add 0.
    - Then bit_idx=0, digit_idx+1. If digit_idx+1==N → DONE, else → SAMPLE.
  - DONE:
    - value <= accumulator, valid=1 for one cycle, busy drops → IDLE.
- Timing:
  - Latency: valid is high in the cycle starting 14*N+1 clock edges after the edge that samples start.
  - next_led is never high in two consecutive cycles.
- Arithmetic and output rules:
  - Maximum result is 999. The accumulator is 10 bits, zero-extended to VALUE_W.
  - value holds until the next DONE. error holds until the next accepted start.
  - start while busy is ignored.
- The host keeps the decoder's data input stable from start until valid. A change in that window is not detected.

Decomposition:
- Package display_pkg (shared with the decoder) holds:
  - the 7-bit segment pattern constants;
  - state_t {IDLE, SAMPLE, STEP, DONE};
  - a seg_to_digit function returning {valid, 4-bit digit}.
- One natural combinational sub-module, seg7_to_digit, wrapping that function. The FSM and accumulator stay in display_stream_reader.

Test Plan:
- Decoder instance as peer, digit_count=3, data=472 → 21 next_led pulses; valid at edge start+43; value=472, error=0; peer_busy ends 0.
- digit_count=0, data=5 → 7 pulses, value=5. digit_count=1, data=8 → value=8.
- digit_count=2, data=1234 → 14 pulses, value=34, error=0.
- Behavioural peer sends pattern 0000000 for digit 1 of a 3-digit read, digits 2 and 7 elsewhere → error=1, value=702, 21 pulses still issued.
- Peer forces peer_busy=0 after the 3rd pulse → error=1, valid early, no further next_led.
- rst_n low mid-read → all outputs 0 immediately. Later, start with peer_busy=1 → busy stays 0, no next_led.
